// File: rtl/muldiv_hilo_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_hilo_ctrl_if                                             |
// | Brief    : EX-stage <-> HI/LO multiply/divide sequencer signal bundle      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface muldiv_hilo_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_md_valid;
    logic [2:0]      ex_md_op;
    logic [XLEN-1:0] ex_busA;
    logic [XLEN-1:0] ex_busB;
    logic            ex_hl_rd;
    logic            flush;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            md_busy;
    logic            md_stall;
    logic            md_done;
    logic            div_zero;

    // Pipeline side: issues ops and reads HI/LO.
    modport master (
        output ex_md_valid, ex_md_op, ex_busA, ex_busB, ex_hl_rd, flush,
        input  hi, lo, md_busy, md_stall, md_done, div_zero
    );

    // Sequencer side.
    modport slave (
        input  ex_md_valid, ex_md_op, ex_busA, ex_busB, ex_hl_rd, flush,
        output hi, lo, md_busy, md_stall, md_done, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_hilo_ctrl                                                |
// | Brief    : HI/LO multiply/divide sequencer with pipeline stall control.    |
// |            Define MULDIV_EARLY_OUT_EN for single-edge |d|>|n| divides.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_hilo_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input wire logic          clk,
    input wire logic          rst_n,
    muldiv_hilo_ctrl_if.slave md
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(XLEN - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]  hi_q,     hi_d;
    logic [XLEN-1:0]  lo_q,     lo_d;
    logic             done_q,   done_d;
    logic             dz_q,     dz_d;
    logic [XLEN-1:0]  opa_q,    opa_d;
    logic [XLEN-1:0]  opb_q,    opb_d;
    logic             msgn_q,   msgn_d;
    logic [XLEN-1:0]  quo_q,    quo_d;
    logic [XLEN-1:0]  rem_q,    rem_d;
    logic [XLEN-1:0]  dvs_q,    dvs_d;
    logic             qneg_q,   qneg_d;
    logic             rneg_q,   rneg_d;
    logic             fast_q,   fast_d;

    logic             w_busy;
    logic             w_accept;
    logic             w_sdiv;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_fast;

    logic [2*XLEN-1:0] w_ext_a;
    logic [2*XLEN-1:0] w_ext_b;
    logic [2*XLEN-1:0] w_prod;

    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;
    logic             w_qbit;
    logic [XLEN-1:0]  w_rem_nx;
    logic [XLEN-1:0]  w_quo_nx;
    logic             w_dzero;

    assign w_busy   = (state_q != S_IDLE);
    assign w_accept = (state_q == S_IDLE) & md.ex_md_valid & ~md.flush;

    // Divide operand conditioning: magnitudes plus sign bookkeeping.
    assign w_sdiv  = (md.ex_md_op == OP_DIV);
    assign w_a_neg = w_sdiv & md.ex_busA[XLEN-1];
    assign w_b_neg = w_sdiv & md.ex_busB[XLEN-1];
    assign w_mag_a = w_a_neg ? (-md.ex_busA) : md.ex_busA;
    assign w_mag_b = w_b_neg ? (-md.ex_busB) : md.ex_busB;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_fast = (w_mag_b == '0) | (w_mag_b > w_mag_a);
`else
    assign w_fast = (w_mag_b == '0);
`endif

    // Sign-extending to 2*XLEN lets one unsigned multiplier serve MULT and MULTU.
    assign w_ext_a = {{XLEN{msgn_q & opa_q[XLEN-1]}}, opa_q};
    assign w_ext_b = {{XLEN{msgn_q & opb_q[XLEN-1]}}, opb_q};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring-divide step; rem_q < dvs_q keeps the trial within XLEN+1 bits.
    assign w_shift  = {rem_q, quo_q[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, dvs_q};
    assign w_qbit   = ~w_trial[XLEN];
    assign w_rem_nx = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nx = {quo_q[XLEN-2:0], w_qbit};
    assign w_dzero  = (dvs_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        opa_d   = opa_q;
        opb_d   = opb_q;
        msgn_d  = msgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        fast_d  = fast_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (md.ex_md_op)
                        OP_MTHI: hi_d = md.ex_busA;
                        OP_MTLO: lo_d = md.ex_busA;
                        OP_MULT, OP_MULTU: begin
                            opa_d   = md.ex_busA;
                            opb_d   = md.ex_busB;
                            msgn_d  = (md.ex_md_op == OP_MULT);
                            cnt_d   = C_MUL_LOAD;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_d   = md.ex_busA;
                            quo_d   = w_mag_a;
                            dvs_d   = w_mag_b;
                            rem_d   = '0;
                            qneg_d  = w_a_neg ^ w_b_neg;
                            rneg_d  = w_a_neg;
                            fast_d  = w_fast;
                            cnt_d   = C_DIV_LOAD;
                            state_d = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = w_prod;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DIV: begin
                if (md.flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (fast_q) begin
                    // Zero divisor or small-over-large: quotient is all-ones or 0.
                    hi_d    = opa_q;
                    lo_d    = w_dzero ? '1 : '0;
                    dz_d    = w_dzero;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = w_rem_nx;
                    quo_d = w_quo_nx;
                    if (cnt_q == '0) begin
                        lo_d    = qneg_q ? (-w_quo_nx) : w_quo_nx;
                        hi_d    = rneg_q ? (-w_rem_nx) : w_rem_nx;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            msgn_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            msgn_q  <= msgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            fast_q  <= fast_d;
        end
    end

    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.md_busy  = w_busy;
    assign md.md_stall = w_busy & (md.ex_md_valid | md.ex_hl_rd);
    assign md.md_done  = done_q;
    assign md.div_zero = dz_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_hilo_ctrl                                             |
// | Brief    : Self-checking bench: arithmetic reference model + directed cases|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_muldiv_hilo_ctrl;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_hilo_ctrl_if #(.XLEN(XLEN)) bus ();

    muldiv_hilo_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    // Architectural result and latency of one accepted mult/div.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rhi, output logic [31:0] rlo,
                                   output logic rdz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        rdz = 1'b0;
        if (op == 3'd0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            rhi = p[63:32]; rlo = p[31:0]; lat = MUL_LAT;
        end else if (op == 3'd1) begin
            p  = {32'h0, a} * {32'h0, b};
            rhi = p[63:32]; rlo = p[31:0]; lat = MUL_LAT;
        end else if (b == 32'h0) begin
            rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; lat = 1;
        end else begin
            if (op == 3'd2) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            q = sa / sb;
            r = sa % sb;
            rlo = q[31:0]; rhi = r[31:0]; lat = XLEN;
`ifdef MULDIV_EARLY_OUT_EN
            if (((sb < 0) ? -sb : sb) > ((sa < 0) ? -sa : sa)) lat = 1;
`endif
        end
    endfunction

    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
    logic        m_pend, m_done, m_dzo, m_rdz;
    int          ecnt, m_wr, m_lat;

    initial begin
        m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0;
        m_pend = 0; m_done = 0; m_dzo = 0; m_rdz = 0; ecnt = 0; m_wr = 0; m_lat = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hi = 0; m_lo = 0; m_pend = 0; m_done = 0; m_dzo = 0; ecnt = 0;
            end else begin
                ecnt++;
                m_done = 0;
                m_dzo  = 0;
                if (m_pend) begin
                    if (bus.flush) begin
                        m_pend = 0;
                    end else if (ecnt == m_wr) begin
                        m_hi = m_rhi; m_lo = m_rlo;
                        m_done = 1; m_dzo = m_rdz; m_pend = 0;
                    end
                end else if (bus.ex_md_valid && !bus.flush) begin
                    if (bus.ex_md_op == 3'd4) m_hi = bus.ex_busA;
                    else if (bus.ex_md_op == 3'd5) m_lo = bus.ex_busA;
                    else if (bus.ex_md_op <= 3'd3) begin
                        ref_op(bus.ex_md_op, bus.ex_busA, bus.ex_busB, m_rhi, m_rlo, m_rdz, m_lat);
                        m_pend = 1;
                        m_wr   = ecnt + m_lat;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk32("hi", bus.hi, m_hi);
            chk32("lo", bus.lo, m_lo);
            chk1("busy", bus.md_busy, m_pend);
            chk1("stall", bus.md_stall, m_pend & (bus.ex_md_valid | bus.ex_hl_rd));
            chk1("done", bus.md_done, m_done);
            chk1("div_zero", bus.div_zero, m_dzo);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.ex_md_valid = 1'b1; bus.ex_md_op = op; bus.ex_busA = a; bus.ex_busB = b;
        @(posedge clk); #1;
        bus.ex_md_valid = 1'b0;
    endtask

    // Returns at the negedge where md_done is seen; busy = cycles md_busy was high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy);
        logic seen;
        busy = 0;
        seen = 1'b0;
        issue(op, a, b);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.md_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.md_busy) busy++;
        end
        chk1("done_seen", seen, 1'b1);
    endtask

    int busy;
    int stalls;
    logic saw_done;

    initial begin
        bus.ex_md_valid = 0; bus.ex_md_op = 0; bus.ex_busA = 0; bus.ex_busB = 0;
        bus.ex_hl_rd = 0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk32("rst_hi", bus.hi, 32'h0);
        chk32("rst_lo", bus.lo, 32'h0);

        // MTLO then MFLO
        @(posedge clk); #1;
        bus.ex_md_valid = 1; bus.ex_md_op = 3'd5; bus.ex_busA = 32'h1234;
        @(negedge clk);
        chk1("mtlo_stall", bus.md_stall, 1'b0);
        @(posedge clk); #1;
        bus.ex_md_valid = 0; bus.ex_hl_rd = 1;
        @(negedge clk);
        chk32("mflo_lo", bus.lo, 32'h0000_1234);
        chk1("mflo_stall", bus.md_stall, 1'b0);
        @(posedge clk); #1 bus.ex_hl_rd = 0;

        // MULT -2 x 3
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, busy);
        chk32("mult_busy", 32'(busy), 32'd3);
        chk32("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk32("mult_lo", bus.lo, 32'hFFFF_FFFA);
        @(negedge clk);
        chk1("mult_done_pulse", bus.md_done, 1'b0);

        // DIV -7/2 with MFHI from e1 onward
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1 bus.ex_hl_rd = 1;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.md_stall) break;
            stalls++;
        end
        chk32("div_stalls", 32'(stalls), 32'd31);
        chk1("div_done", bus.md_done, 1'b1);
        chk32("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk32("div_lo", bus.lo, 32'hFFFF_FFFD);
        @(posedge clk); #1 bus.ex_hl_rd = 0;

        // DIVU 5/0
        run_op(3'd3, 32'd5, 32'd0, busy);
        chk32("dz_busy", 32'(busy), 32'd1);
        chk1("dz_flag", bus.div_zero, 1'b1);
        chk32("dz_hi", bus.hi, 32'd5);
        chk32("dz_lo", bus.lo, 32'hFFFF_FFFF);

        // DIVU 100/7 flushed at e10
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1;
        @(posedge clk); #1 bus.flush = 0;
        @(negedge clk);
        chk1("flush_busy", bus.md_busy, 1'b0);
        chk32("flush_hi", bus.hi, 32'd5);
        chk32("flush_lo", bus.lo, 32'hFFFF_FFFF);
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); saw_done = saw_done | bus.md_done; end
        chk1("flush_no_done", saw_done, 1'b0);

        // Flush in the accept cycle drops the op
        @(posedge clk); #1;
        bus.ex_md_valid = 1; bus.ex_md_op = 3'd0; bus.ex_busA = 32'd2; bus.ex_busB = 32'd2; bus.flush = 1;
        @(posedge clk); #1;
        bus.ex_md_valid = 0; bus.flush = 0;
        @(negedge clk);
        chk1("drop_busy", bus.md_busy, 1'b0);
        chk32("drop_lo", bus.lo, 32'hFFFF_FFFF);

        // DIVU 3/9: latency depends on early-out build
        run_op(3'd3, 32'd3, 32'd9, busy);
`ifdef MULDIV_EARLY_OUT_EN
        chk32("small_busy", 32'(busy), 32'd1);
`else
        chk32("small_busy", 32'(busy), 32'd32);
`endif
        chk32("small_hi", bus.hi, 32'd3);
        chk32("small_lo", bus.lo, 32'd0);

        // Most-negative / -1 wraps
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, busy);
        chk32("ovf_busy", 32'(busy), 32'd32);
        chk32("ovf_hi", bus.hi, 32'h0);
        chk32("ovf_lo", bus.lo, 32'h8000_0000);

        // MULTU full-width
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy);
        chk32("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk32("multu_lo", bus.lo, 32'h0000_0001);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.ex_md_valid = ($urandom_range(0, 2) == 0);
            bus.ex_md_op    = 3'($urandom_range(0, 7));
            bus.ex_busA     = rnd_val();
            bus.ex_busB     = rnd_val();
            bus.ex_hl_rd    = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #1;
        bus.ex_md_valid = 0; bus.ex_hl_rd = 0; bus.flush = 0;

        // Reset in the middle of a multiply
        issue(3'd1, 32'd1000, 32'd1000);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mrst_busy", bus.md_busy, 1'b0);
        chk32("mrst_hi", bus.hi, 32'h0);
        chk32("mrst_lo", bus.lo, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk32("mrst_lo_after", bus.lo, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
